mem_stage_memwb: RTL and testbench

- MEM pipeline stage plus MEM/WB pipeline register.
- Consumes the EX/MEM buffer outputs and runs the data-memory access over a req/ack handshake with a variable-latency data memory.
- Raises a stall so upstream stages freeze while an access is pending, then registers write-back data for the WB stage.
- Resolves branch taken/target combinationally for the IF stage.

---
 rtl/mem_stage_memwb.sv | 178 +++++++++++++++++
 tb/tb_mem_stage_memwb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_memwb.sv
// ---------------------------------------------------------------------------
// mem_stage_memwb
//   MEM pipeline stage plus the MEM/WB pipeline register.
//   - Runs loads/stores over a req/ack handshake with a variable-latency data
//     memory. While an access is outstanding, O_Stall freezes the upstream
//     stages (PC, IF/ID, ID/EX, EX/MEM).
//   - Registers write-back control, ALU result, load data and destination
//     register for the WB stage. A bubble (O_WB=0) is inserted every stalled
//     cycle.
//   - Resolves branch taken/target combinationally for IF.
//
// Optional feature (macro MEM_TIMEOUT_EN):
//   Bounds the wait for mem_ack to TIMEOUT_CYCLES BUSY cycles. On expiry the
//   access is abandoned, a bubble is written back and O_Err is set sticky.
//   Without the macro BUSY waits forever and O_Err is tied to 0.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   I_WB[1:0]            write-back control ([0]=RegWrite, [1]=MemtoReg)
//   I_M_Branch           branch instruction flag
//   I_M_MemRead/Write    load / store request
//   I_ADD_Res[31:0]      branch target address
//   I_ZF                 ALU zero flag
//   I_ALU_Res[31:0]      ALU result, also memory address
//   I_DatWri_Mem[31:0]   store data
//   I_Addr_Reg_Wri[4:0]  destination register
//   mem_rdata, mem_ack   memory read data / completion strobe
//   mem_req, mem_we      access request (held until ack) / write enable
//   mem_addr, mem_wdata  access address / store data
//   O_Stall              upstream freeze
//   O_PCSrc              branch taken
//   O_Branch_Target      branch target (= I_ADD_Res)
//   O_WB, O_MemData,
//   O_ALU_Res,
//   O_Addr_Reg_Wri       MEM/WB register outputs
//   O_Err                sticky access-timeout flag
// ---------------------------------------------------------------------------
module mem_stage_memwb #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  I_WB,
  input  logic        I_M_Branch,
  input  logic        I_M_MemRead,
  input  logic        I_M_MemWrite,
  input  logic [31:0] I_ADD_Res,
  input  logic        I_ZF,
  input  logic [31:0] I_ALU_Res,
  input  logic [31:0] I_DatWri_Mem,
  input  logic [4:0]  I_Addr_Reg_Wri,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        O_Stall,
  output logic        O_PCSrc,
  output logic [31:0] O_Branch_Target,
  output logic [1:0]  O_WB,
  output logic [31:0] O_MemData,
  output logic [31:0] O_ALU_Res,
  output logic [4:0]  O_Addr_Reg_Wri,
  output logic        O_Err
);

  typedef enum logic {IDLE, BUSY} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  wb_q;
  logic [31:0] mem_data_q;
  logic [31:0] alu_res_q;
  logic [4:0]  rd_q;

  logic        acc;
  logic        busy;
  logic        timeout;

  assign acc  = I_M_MemRead | I_M_MemWrite;
  assign busy = (state_q == BUSY);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  // cnt_q holds the number of ack-less BUSY cycles already elapsed, so the
  // TIMEOUT_CYCLES-th BUSY cycle is the one where cnt_q == TIMEOUT_CYCLES-1.
  // An ack in that same cycle takes priority (timeout is masked by ~mem_ack).
  assign timeout = busy & ~mem_ack & (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      // Held at zero in IDLE, so every BUSY episode starts from zero.
      if (!busy)         cnt_q <= '0;
      else if (!mem_ack) cnt_q <= cnt_q + 8'd1;
      if (timeout)       err_q <= 1'b1;
    end
  end

  assign O_Err = err_q;
`else
  assign timeout = 1'b0;
  assign O_Err   = 1'b0;
`endif

  // Combinational stall: IDLE launching an access, or BUSY still waiting.
  assign O_Stall         = (~busy & acc) | (busy & ~mem_ack & ~timeout);
  assign O_PCSrc         = I_M_Branch & I_ZF & ~O_Stall;
  assign O_Branch_Target = I_ADD_Res;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_q        <= '0;
      mem_data_q  <= '0;
      alu_res_q   <= '0;
      rd_q        <= '0;
    end else if (!busy) begin
      if (acc) begin
        state_q     <= BUSY;
        mem_req_q   <= 1'b1;
        mem_we_q    <= I_M_MemWrite;   // write wins when both are set
        mem_addr_q  <= I_ALU_Res;
        mem_wdata_q <= I_DatWri_Mem;
        wb_q        <= '0;             // bubble; other fields keep values
      end else begin
        // mem_ack in IDLE is deliberately ignored.
        wb_q       <= I_WB;
        alu_res_q  <= I_ALU_Res;
        rd_q       <= I_Addr_Reg_Wri;
        mem_data_q <= '0;
      end
    end else begin
      if (mem_ack) begin
        state_q    <= IDLE;
        mem_req_q  <= 1'b0;
        wb_q       <= I_WB;
        alu_res_q  <= I_ALU_Res;
        rd_q       <= I_Addr_Reg_Wri;
        mem_data_q <= mem_we_q ? 32'd0 : mem_rdata;
      end else if (timeout) begin
        state_q   <= IDLE;
        mem_req_q <= 1'b0;
        wb_q      <= '0;
      end else begin
        wb_q <= '0;
      end
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign O_WB           = wb_q;
  assign O_MemData      = mem_data_q;
  assign O_ALU_Res      = alu_res_q;
  assign O_Addr_Reg_Wri = rd_q;

endmodule

// File: tb/tb_mem_stage_memwb.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_memwb
//   Directed bench for mem_stage_memwb. Retiring instructions (O_WB != 0) are
//   matched against a scoreboard queue filled when the instruction is issued;
//   handshake, stall and branch behaviour are checked inline.
//   Built with or without MEM_TIMEOUT_EN (DUT uses TIMEOUT_CYCLES=4).
// ---------------------------------------------------------------------------
module tb_mem_stage_memwb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  I_WB;
  logic        I_M_Branch, I_M_MemRead, I_M_MemWrite, I_ZF;
  logic [31:0] I_ADD_Res, I_ALU_Res, I_DatWri_Mem, mem_rdata;
  logic [4:0]  I_Addr_Reg_Wri;
  logic        mem_ack;
  logic        mem_req, mem_we, O_Stall, O_PCSrc, O_Err;
  logic [31:0] mem_addr, mem_wdata, O_Branch_Target, O_MemData, O_ALU_Res;
  logic [1:0]  O_WB;
  logic [4:0]  O_Addr_Reg_Wri;

  mem_stage_memwb #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .I_WB(I_WB), .I_M_Branch(I_M_Branch), .I_M_MemRead(I_M_MemRead),
    .I_M_MemWrite(I_M_MemWrite), .I_ADD_Res(I_ADD_Res), .I_ZF(I_ZF),
    .I_ALU_Res(I_ALU_Res), .I_DatWri_Mem(I_DatWri_Mem),
    .I_Addr_Reg_Wri(I_Addr_Reg_Wri), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .O_Stall(O_Stall), .O_PCSrc(O_PCSrc),
    .O_Branch_Target(O_Branch_Target), .O_WB(O_WB), .O_MemData(O_MemData),
    .O_ALU_Res(O_ALU_Res), .O_Addr_Reg_Wri(O_Addr_Reg_Wri), .O_Err(O_Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [31:0] md;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Monitor: every retiring instruction must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && O_WB != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", {30'd0, O_WB}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ret_wb", {30'd0, O_WB}, {30'd0, e.wb});
        check("ret_alu", O_ALU_Res, e.alu);
        check("ret_memdata", O_MemData, e.md);
        check("ret_rd", {27'd0, O_Addr_Reg_Wri}, {27'd0, e.rd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_nop();
    I_WB = 2'b00; I_M_Branch = 1'b0; I_M_MemRead = 1'b0; I_M_MemWrite = 1'b0;
    I_ZF = 1'b0; I_ADD_Res = '0; I_ALU_Res = '0; I_DatWri_Mem = '0;
    I_Addr_Reg_Wri = '0;
  endtask

  // Non-memory op; called at a negedge, returns at the next negedge.
  task automatic alu_op(input logic [1:0] wb, input logic [31:0] alu,
                        input logic [4:0] rd);
    I_WB = wb; I_ALU_Res = alu; I_Addr_Reg_Wri = rd;
    #1 check("alu_stall", {31'd0, O_Stall}, 32'd0);
    if (wb != 2'b00) sb.push_back('{wb, alu, 32'd0, rd});
    @(negedge clk);
    set_nop();
  endtask

  // Memory op: ack arrives in BUSY cycle wait_cycles+1. Called at a negedge,
  // returns at the negedge after the completion edge.
  task automatic mem_op(input logic rd_en, input logic wr_en,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] wb, input logic [4:0] rd,
                        input int wait_cycles, input logic [31:0] rdata,
                        input logic [31:0] exp_md,
                        output int stalls, output int reqs);
    int  busy_n = 0;
    bit  done   = 0;
    stalls = 0;
    reqs   = 0;
    I_M_MemRead = rd_en; I_M_MemWrite = wr_en; I_ALU_Res = addr;
    I_DatWri_Mem = wdata; I_WB = wb; I_Addr_Reg_Wri = rd;
    sb.push_back('{wb, addr, exp_md, rd});
    for (int c = 0; c < 40 && !done; c++) begin
      if (mem_req) begin
        busy_n++;
        reqs++;
        check("busy_addr", mem_addr, addr);
        check("busy_we", {31'd0, mem_we}, {31'd0, wr_en});
        if (wr_en) check("busy_wdata", mem_wdata, wdata);
        check("busy_bubble", {30'd0, O_WB}, 32'd0);
        if (busy_n > wait_cycles) begin
          mem_ack = 1'b1; mem_rdata = rdata; done = 1;
        end
      end
      #1 if (O_Stall) stalls++;
      @(negedge clk);
    end
    mem_ack = 1'b0; mem_rdata = '0;
    set_nop();
    if (!done) check("mem_op_no_req_seen", 32'd0, 32'd1);
  endtask

  initial begin
    int st, rq, busy_n;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    set_nop();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_O_WB", {30'd0, O_WB}, 32'd0);
    check("rst_O_ALU_Res", O_ALU_Res, 32'd0);
    check("rst_O_MemData", O_MemData, 32'd0);
    check("rst_O_Err", {31'd0, O_Err}, 32'd0);
    check("rst_O_Stall", {31'd0, O_Stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Pass-through ALU ops, back to back
    alu_op(2'b01, 32'h0000_0010, 5'd8);
    alu_op(2'b11, 32'hFFFF_FFFF, 5'd31);

    // Ack while IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
    alu_op(2'b01, 32'h0000_0055, 5'd3);
    check("idle_ack_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0; mem_rdata = '0;

    // Branch resolution
    I_M_Branch = 1'b1; I_ZF = 1'b1; I_ADD_Res = 32'h0000_0100;
    #1 check("br_taken", {31'd0, O_PCSrc}, 32'd1);
    check("br_target", O_Branch_Target, 32'h0000_0100);
    I_ZF = 1'b0;
    #1 check("br_not_taken", {31'd0, O_PCSrc}, 32'd0);
    I_ZF = 1'b1; I_M_MemRead = 1'b1;
    #1 check("br_masked_by_stall", {31'd0, O_PCSrc}, 32'd0);
    set_nop();
    @(negedge clk);

    // Load with three ack-less BUSY cycles
    mem_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 2'b11, 5'd5, 3, 32'hDEAD_BEEF,
           32'hDEAD_BEEF, st, rq);
    check("load_stall_cycles", st, 32'd4);
    check("load_req_cycles", rq, 32'd4);

    // Zero-wait store
    mem_op(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 2'b10, 5'd0, 0,
           32'hCAFE_F00D, 32'h0, st, rq);
    check("store_stall_cycles", st, 32'd1);
    check("store_req_cycles", rq, 32'd1);
    check("store_req_dropped", {31'd0, mem_req}, 32'd0);

    // Read and write together: write wins, no load data
    mem_op(1'b1, 1'b1, 32'h0000_00C0, 32'h0BAD_0BAD, 2'b11, 5'd9, 1,
           32'hFFFF_FFFF, 32'h0, st, rq);
    check("rw_stall_cycles", st, 32'd2);

    alu_op(2'b01, 32'h0000_0077, 5'd12);

`ifdef MEM_TIMEOUT_EN
    // Load without ack: released in the 4th BUSY cycle
    I_M_MemRead = 1'b1; I_ALU_Res = 32'h0000_0200; I_WB = 2'b11;
    busy_n = 0;
    for (int c = 0; c < 20; c++) begin
      #1 if (mem_req) busy_n++;
      if (!O_Stall) break;
      @(negedge clk);
    end
    check("to_busy_cycles", busy_n, 32'd4);
    set_nop();
    @(negedge clk);
    check("to_req_dropped", {31'd0, mem_req}, 32'd0);
    check("to_err_set", {31'd0, O_Err}, 32'd1);
    check("to_bubble", {30'd0, O_WB}, 32'd0);
    alu_op(2'b01, 32'h0000_0099, 5'd4);
    check("to_err_sticky", {31'd0, O_Err}, 32'd1);
    // Start another access and abandon it with reset
    I_M_MemRead = 1'b1; I_ALU_Res = 32'h0000_0300; I_WB = 2'b11;
    repeat (2) @(negedge clk);
`else
    // Load without ack: waits indefinitely
    I_M_MemRead = 1'b1; I_ALU_Res = 32'h0000_0200; I_WB = 2'b11;
    @(negedge clk);
    busy_n = 0;
    for (int c = 0; c < 50; c++) begin
      #1 if (O_Stall && mem_req) busy_n++;
      @(negedge clk);
    end
    check("hang_stall_cycles", busy_n, 32'd50);
    check("hang_err", {31'd0, O_Err}, 32'd0);
`endif

    // Reset mid-BUSY
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1 check("rst_busy_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy_wb", {30'd0, O_WB}, 32'd0);
    check("rst_busy_alu", O_ALU_Res, 32'd0);
    check("rst_busy_rd", {27'd0, O_Addr_Reg_Wri}, 32'd0);
    check("rst_busy_err", {31'd0, O_Err}, 32'd0);
    set_nop();
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_stall", {31'd0, O_Stall}, 32'd0);
    check("late_ack_memdata", O_MemData, 32'd0);
    mem_ack = 1'b0; mem_rdata = '0;

    // Normal operation after reset
    alu_op(2'b01, 32'h0000_0123, 5'd7);
    @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
